serial_pattern_src: RTL
=======================

SERIAL_PATTERN_SRC -- requirements
Module: serial_pattern_src

Interface
REQ-001 SHALL have parameter WIDTH, default 8: shift-register width and maximum pattern length in bits.
REQ-002 SHALL have port CLK, input, 1 bit: single clock; all state changes on the rising edge.
REQ-003 SHALL have port RESET, input, 1 bit: asynchronous, active-high reset.
REQ-004 SHALL have port start, input, 1 bit: request to send a pattern, sampled on the rising edge of CLK.
REQ-005 SHALL have port load_data, input, WIDTH bits: pattern captured when start is accepted.
REQ-006 SHALL have port len, input, 4 bits: number of bits to send; 0 or any value greater than WIDTH means WIDTH.
REQ-007 SHALL have port x, output, 1 bit: registered serial bit that drives the downstream FSM's x input.
REQ-008 SHALL have port busy, output, 1 bit: high while pattern bits are presented on x.
REQ-009 SHALL have port done, output, 1 bit: one-cycle pulse after the last bit.
REQ-010 SHALL have port bit_idx, output, 3 bits: index of the bit currently on x, counting 0 to L-1 from pattern start.

Function
REQ-011 SHALL implement three states: IDLE, SHIFT and DONE. All outputs SHALL be registered.
REQ-012 IDLE: on an edge with start=1, SHALL latch load_data and the effective length L, then go to SHIFT.
- On that same edge: x <= load_data[WIDTH-1], busy <= 1, bit_idx <= 0.
REQ-013 SHIFT behaviour:
- In cycle k after acceptance (k = 1..L), x SHALL equal load_data[WIDTH-k], MSB first.
- busy SHALL be 1 and bit_idx SHALL be k-1.
REQ-014 After the cycle that presents bit L, the next edge SHALL enter DONE.
- In DONE: x=0, busy=0, done=1.
REQ-015 DONE SHALL last exactly one cycle, then return to IDLE unconditionally. done SHALL be 0 in every other state.
REQ-016 In IDLE, outputs SHALL be x=0, busy=0, done=0, bit_idx=0.
REQ-017 start asserted in SHIFT or DONE SHALL be ignored; a new pattern is accepted no earlier than the first IDLE edge.
- Minimum spacing between pattern starts is L+2 cycles.
REQ-018 Changes to load_data or len after acceptance SHALL have no effect on the pattern in flight.
REQ-019 Effective-length rule: L=len for 1 <= len <= WIDTH, else L=WIDTH. L=1 SHALL produce one busy cycle followed by DONE.

Reset
REQ-020 RESET=1 SHALL immediately, without waiting for CLK, force:
- state=IDLE, x=0, busy=0, done=0, bit_idx=0;
- shift register and length counter cleared.
REQ-021 RESET during SHIFT SHALL abort the pattern with no done pulse.
- start on the first edge after RESET deasserts SHALL be accepted normally.

Configuration
REQ-022 Macro SERIAL_PATTERN_SRC_LOOP_MODE_EN SHALL control loop mode.
- Defined: if start=1 on the edge that ends bit L, the block SHALL:
  - reload the latched pattern, not load_data;
  - present bit WIDTH-1 next cycle with bit_idx=0;
  - keep busy=1 continuously, with no DONE state between repetitions.
- Defined: when start=0 on that edge, the block SHALL go to DONE per REQ-014.
- Not defined: start in SHIFT is ignored per REQ-017; no loop logic is synthesized.

Verification
REQ-023 Basic pattern:
- Stimulus: load_data=8'b10110010, len=8, start pulsed 1 cycle.
- Required: x = 1,0,1,1,0,0,1,0 on cycles 1..8, busy high exactly 8 cycles, done high on cycle 9 only, then IDLE.
REQ-024 Short length:
- Stimulus: load_data=8'b11000000, len=3.
- Required: x = 1,1,0; bit_idx = 0,1,2; done on cycle 4.
- Stimulus: len=0, then len=12.
- Required: each sends all 8 bits.
REQ-025 Ignored restart:
- Stimulus: start held high and load_data changed to 8'hFF during SHIFT of 8'h0F.
- Required: x = 0,0,0,0,1,1,1,1; a new 8'hFF pattern starts only after the DONE cycle.
REQ-026 Reset mid-pattern:
- Stimulus: RESET asserted asynchronously between clock edges during bit 4.
- Required: x, busy and bit_idx go to 0 before the next edge; no done pulse; a start accepted 1 edge after release.
REQ-027 Loop mode (macro defined):
- Stimulus: 8'hA5 with start held high for 20 cycles.
- Required: x repeats 1010_0101 with no gap and busy stays 1; done appears once, after start drops at a pattern end.
- Required with macro undefined: single pattern, then done.
REQ-028 Downstream chain:
- Stimulus: x connected to the downstream FSM with shared CLK/RESET.
- Required: its S/F sequence matches that FSM's reference model for the same bit stream.

Source files
------------

// File: rtl/serial_pattern_src.sv
// ---------------------------------------------------------------------------
// serial_pattern_src
//
// Purpose:
//   Serialises a parallel pattern onto a single registered bit, MSB first,
//   so it can drive the x input of a downstream FSM. A pattern of L bits
//   (1..WIDTH) is captured when start is accepted in IDLE. Each bit is held
//   on x for one cycle. After the last bit a one-cycle DONE state pulses
//   done, and the block then returns to IDLE.
//
// Parameters:
//   WIDTH      shift-register width and maximum pattern length in bits (>= 2)
//
// Ports:
//   CLK        single clock; all state changes on the rising edge
//   RESET      asynchronous, active-high reset
//   start      request to send a pattern (ignored outside IDLE)
//   load_data  pattern captured when start is accepted
//   len        bits to send; 0 or any value above WIDTH means WIDTH
//   x          registered serial bit
//   busy       high while pattern bits are presented on x
//   done       one-cycle pulse in the cycle after the last bit
//   bit_idx    index of the bit currently on x (0 .. L-1)
//
// Configuration:
//   SERIAL_PATTERN_SRC_LOOP_MODE_EN
//     When defined, start held high on the edge that ends the last bit
//     replays the latched pattern back-to-back. busy stays high and no DONE
//     cycle occurs between repetitions. When undefined, no loop logic exists.
// ---------------------------------------------------------------------------
module serial_pattern_src #(
  parameter int WIDTH = 8
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             start,
  input  logic [WIDTH-1:0] load_data,
  input  logic [3:0]       len,
  output logic             x,
  output logic             busy,
  output logic             done,
  output logic [2:0]       bit_idx
);

  // Width of the bit counter: it only has to reach WIDTH-1.
  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_shift;
  logic [CW-1:0]    r_last;
  logic [CW-1:0]    r_cnt;
  logic             r_x;
  logic             r_busy;
  logic             r_done;

  state_t           w_nextState;
  logic [WIDTH-1:0] w_nextShift;
  logic [CW-1:0]    w_nextLast;
  logic [CW-1:0]    w_nextCnt;
  logic             w_nextX;
  logic             w_nextBusy;
  logic             w_nextDone;
  logic [CW-1:0]    w_effLast;

`ifdef SERIAL_PATTERN_SRC_LOOP_MODE_EN
  // Copy of the accepted pattern, kept so a loop replay does not depend on
  // the live load_data input.
  logic [WIDTH-1:0] r_pattern;
  logic [WIDTH-1:0] w_nextPattern;
`endif

  // Index of the last bit to send. An out-of-range len (0 or above WIDTH)
  // selects the full register.
  always_comb begin
    if ((len == 4'd0) || (int'(len) > WIDTH)) begin
      w_effLast = CW'(WIDTH - 1);
    end else begin
      w_effLast = CW'(int'(len) - 1);
    end
  end

  // Next-state and next-output logic. Every output is computed here and
  // registered below, so x/busy/done/bit_idx change only on a clock edge.
  // The shift register already holds the remaining bits left-justified.
  // The next bit to present is therefore always its MSB.
  always_comb begin
    w_nextState = r_state;
    w_nextShift = r_shift;
    w_nextLast  = r_last;
    w_nextCnt   = '0;
    w_nextX     = 1'b0;
    w_nextBusy  = 1'b0;
    w_nextDone  = 1'b0;
`ifdef SERIAL_PATTERN_SRC_LOOP_MODE_EN
    w_nextPattern = r_pattern;
`endif

    case (r_state)
      IDLE: begin
        if (start) begin
          w_nextState = SHIFT;
          w_nextShift = load_data << 1;
          w_nextLast  = w_effLast;
          w_nextX     = load_data[WIDTH-1];
          w_nextBusy  = 1'b1;
`ifdef SERIAL_PATTERN_SRC_LOOP_MODE_EN
          w_nextPattern = load_data;
`endif
        end
      end

      SHIFT: begin
        if (r_cnt == r_last) begin
`ifdef SERIAL_PATTERN_SRC_LOOP_MODE_EN
          if (start) begin
            w_nextState = SHIFT;
            w_nextShift = r_pattern << 1;
            w_nextX     = r_pattern[WIDTH-1];
            w_nextBusy  = 1'b1;
          end else begin
            w_nextState = DONE;
            w_nextDone  = 1'b1;
          end
`else
          w_nextState = DONE;
          w_nextDone  = 1'b1;
`endif
        end else begin
          w_nextShift = r_shift << 1;
          w_nextX     = r_shift[WIDTH-1];
          w_nextBusy  = 1'b1;
          w_nextCnt   = r_cnt + CW'(1);
        end
      end

      DONE: begin
        w_nextState = IDLE;
      end

      default: begin
        w_nextState = IDLE;
      end
    endcase
  end

  // State and output registers. Reset clears everything without waiting for
  // a clock, which also aborts an in-flight pattern with no done pulse.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_state <= IDLE;
      r_shift <= '0;
      r_last  <= '0;
      r_cnt   <= '0;
      r_x     <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_nextState;
      r_shift <= w_nextShift;
      r_last  <= w_nextLast;
      r_cnt   <= w_nextCnt;
      r_x     <= w_nextX;
      r_busy  <= w_nextBusy;
      r_done  <= w_nextDone;
    end
  end

`ifdef SERIAL_PATTERN_SRC_LOOP_MODE_EN
  // Latched pattern for loop replays.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_pattern <= '0;
    end else begin
      r_pattern <= w_nextPattern;
    end
  end
`endif

  assign x    = r_x;
  assign busy = r_busy;
  assign done = r_done;

  // bit_idx is a fixed 3-bit port. Fit the internal counter to it.
  generate
    if (CW >= 3) begin : gIdxTrunc
      assign bit_idx = r_cnt[2:0];
    end else begin : gIdxExt
      assign bit_idx = {{(3 - CW){1'b0}}, r_cnt};
    end
  endgenerate

endmodule
